// File: rtl/axis2ram_pkg.sv
// Shared types and default geometry for the AXIS-to-RAM frame writer.
package axis2ram_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE, DRAIN} state_t;

    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned DEF_TDATA_W = 24;
    localparam int unsigned DEF_ADDR_W  = 20;
    localparam int unsigned DEF_COL_W   = 11;
    localparam int unsigned DEF_ROW_W   = 10;
    localparam int unsigned DEF_IMG_W   = 640;
    localparam int unsigned DEF_IMG_H   = 480;

    // BT.601 luma weights scaled by 256
    localparam int unsigned GRAY_R = 77;
    localparam int unsigned GRAY_G = 150;
    localparam int unsigned GRAY_B = 29;

endpackage

// File: rtl/axis2ram_addr_calc.sv
// S1/S2 of the write pipeline: row*IMG_W + col address and write data, flushed by reset.
// Define AXIS2RAM_GRAY_EN to convert RGB888 to 8-bit luma across the same two stages.
module axis2ram_addr_calc
    import axis2ram_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PIX_W  = DEF_DATA_W,
    parameter int unsigned COL_W  = DEF_COL_W,
    parameter int unsigned ROW_W  = DEF_ROW_W,
    parameter int unsigned IMG_W  = DEF_IMG_W
) (
    input  logic              clk,
    input  logic              flush,
    input  logic              s0_wv,
    input  logic [ROW_W-1:0]  s0_row,
    input  logic [COL_W-1:0]  s0_col,
    input  logic [PIX_W-1:0]  s0_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din
);

    localparam logic signed [ADDR_W-1:0] IMG_W_S = ADDR_W'(IMG_W);

    logic signed [ADDR_W-1:0] row_s;
    logic                     s1_wv;
    logic [ADDR_W-1:0]        s1_prod;
    logic [COL_W-1:0]         s1_col;

    assign row_s = ADDR_W'(s0_row);

    // Address path; product and sum wrap modulo 2^ADDR_W
    always_ff @(posedge clk) begin
        if (flush) begin
            s1_wv    <= 1'b0;
            s1_prod  <= '0;
            s1_col   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
        end else begin
            s1_wv    <= s0_wv;
            s1_prod  <= ADDR_W'(row_s * IMG_W_S);
            s1_col   <= s0_col;
            ram_we   <= s1_wv;
            ram_addr <= s1_prod + ADDR_W'(s1_col);
        end
    end

`ifdef AXIS2RAM_GRAY_EN
    localparam int unsigned PROD_W = DATA_W + 8;
    localparam int unsigned SUM_W  = PROD_W + 2;

    logic [PROD_W-1:0] s1_r, s1_g, s1_b;
    logic [SUM_W-1:0]  gray_sum;
    logic [SUM_W-1:0]  gray_shr;
    logic [DATA_W-1:0] gray_val;

    always_comb begin
        gray_sum = SUM_W'(s1_r) + SUM_W'(s1_g) + SUM_W'(s1_b);
        gray_shr = gray_sum >> 8;
        gray_val = DATA_W'(gray_shr);
        if (gray_shr > SUM_W'((1 << DATA_W) - 1)) begin
            gray_val = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
            ram_din <= '0;
        end else begin
            s1_r    <= PROD_W'(GRAY_R) * PROD_W'(s0_data[2*DATA_W +: DATA_W]);
            s1_g    <= PROD_W'(GRAY_G) * PROD_W'(s0_data[DATA_W +: DATA_W]);
            s1_b    <= PROD_W'(GRAY_B) * PROD_W'(s0_data[0 +: DATA_W]);
            ram_din <= gray_val;
        end
    end
`else
    logic [DATA_W-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (flush) begin
            s1_data <= '0;
            ram_din <= '0;
        end else begin
            s1_data <= DATA_W'(s0_data);
            ram_din <= s1_data;
        end
    end
`endif

endmodule

// File: rtl/axis2ram_wr_ctrl.sv
// AXI4-Stream video sink: one frame per ap_start, pixels written linearly to the frame-buffer RAM.
// Define AXIS2RAM_GRAY_EN to write RGB888 luma instead of the low tdata bits.
module axis2ram_wr_ctrl
    import axis2ram_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TDATA_W = DEF_TDATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned COL_W   = DEF_COL_W,
    parameter int unsigned ROW_W   = DEF_ROW_W,
    parameter int unsigned IMG_W   = DEF_IMG_W,
    parameter int unsigned IMG_H   = DEF_IMG_H
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    output logic               ap_idle,
    output logic               ap_done,
    input  logic [TDATA_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_din,
    output logic               err_eol,
    output logic               err_sof
);

`ifdef AXIS2RAM_GRAY_EN
    localparam int unsigned PIX_W = TDATA_W;
`else
    localparam int unsigned PIX_W = DATA_W;
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata[TDATA_W-1:DATA_W];
`endif

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             full;

    logic             s0_wv;
    logic [ROW_W-1:0] s0_row;
    logic [COL_W-1:0] s0_col;
    logic [PIX_W-1:0] s0_data;

    logic             acc, take, wr, at_end, eol_hit, sof_hit, last;
    logic             b_full, n_full;
    logic [ROW_W-1:0] b_row, n_row;
    logic [COL_W-1:0] b_col, n_col;

    // Beat classification; a tuser beat always lands at (0,0)
    always_comb begin
        acc     = s_axis_tvalid && s_axis_tready;
        take    = acc && ((state == ACTIVE) || ((state == WAIT_SOF) && s_axis_tuser));
        b_row   = s_axis_tuser ? '0 : row;
        b_col   = s_axis_tuser ? '0 : col;
        b_full  = s_axis_tuser ? 1'b0 : full;
        wr      = take && !b_full;
        at_end  = (b_col == COL_W'(IMG_W - 1));
        n_row   = b_row;
        n_col   = b_col;
        n_full  = b_full;
        if (s_axis_tlast) begin
            n_row  = b_row + ROW_W'(1);
            n_col  = '0;
            n_full = 1'b0;
        end else if (at_end) begin
            n_full = 1'b1;
        end else begin
            n_col = b_col + COL_W'(1);
        end
        eol_hit = take && (b_full || (s_axis_tlast && !at_end));
        sof_hit = acc && (state == ACTIVE) && s_axis_tuser;
        last    = take && s_axis_tlast && (b_row == ROW_W'(IMG_H - 1));
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state         <= IDLE;
            ap_idle       <= 1'b1;
            ap_done       <= 1'b0;
            s_axis_tready <= 1'b0;
            err_eol       <= 1'b0;
            err_sof       <= 1'b0;
            row           <= '0;
            col           <= '0;
            full          <= 1'b0;
            s0_wv         <= 1'b0;
            s0_row        <= '0;
            s0_col        <= '0;
            s0_data       <= '0;
        end else begin
            ap_done <= 1'b0;
            s0_wv   <= wr;
            s0_row  <= b_row;
            s0_col  <= b_col;
            s0_data <= s_axis_tdata[PIX_W-1:0];
            if (take) begin
                row  <= n_row;
                col  <= n_col;
                full <= n_full;
            end
            if (eol_hit) err_eol <= 1'b1;
            if (sof_hit) err_sof <= 1'b1;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state         <= WAIT_SOF;
                        ap_idle       <= 1'b0;
                        s_axis_tready <= 1'b1;
                        err_eol       <= 1'b0;
                        err_sof       <= 1'b0;
                    end
                end
                WAIT_SOF: begin
                    if (take) state <= ACTIVE;
                end
                ACTIVE: ;
                DRAIN: begin
                    // S0 empty means the last write is leaving S1 on this edge
                    if (!s0_wv) begin
                        ap_done <= 1'b1;
                        if (ap_start) begin
                            state         <= WAIT_SOF;
                            s_axis_tready <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            ap_idle <= 1'b1;
                        end
                    end
                end
            endcase
            if (last) begin
                state         <= DRAIN;
                s_axis_tready <= 1'b0;
                row           <= '0;
                col           <= '0;
                full          <= 1'b0;
            end
        end
    end

    axis2ram_addr_calc #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PIX_W  (PIX_W),
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .IMG_W  (IMG_W)
    ) u_addr_calc (
        .clk      (ap_clk),
        .flush    (ap_rst),
        .s0_wv    (s0_wv),
        .s0_row   (s0_row),
        .s0_col   (s0_col),
        .s0_data  (s0_data),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din)
    );

endmodule
